// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: glyph codes,
// the all-off segment pattern and the code-to-segment decoder.
package seg_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEG_W  = 7;

  localparam logic [CODE_W-1:0] GLY_DASH  = 5'd16;
  localparam logic [CODE_W-1:0] GLY_I     = 5'd17;
  localparam logic [CODE_W-1:0] GLY_N     = 5'd18;
  localparam logic [CODE_W-1:0] GLY_W     = 5'd19;
  localparam logic [CODE_W-1:0] GLY_BLANK = 5'd31;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a glyph code
  function automatic logic [SEG_W-1:0] glyph7(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] seg;
    case (code)
      5'd0:    seg = 7'h40;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = 7'h00;
      5'd9:    seg = 7'h10;
      5'd10:   seg = 7'h08;
      5'd11:   seg = 7'h03;
      5'd12:   seg = 7'h46;
      5'd13:   seg = 7'h21;
      5'd14:   seg = 7'h06;
      5'd15:   seg = 7'h0E;
      5'd16:   seg = 7'h3F;
      5'd17:   seg = 7'h4F;
      5'd18:   seg = 7'h48;
      5'd19:   seg = 7'h62;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Refresh timebase: divides clk into PWM sub-ticks (16 per digit slot) and
// steps the scanned digit index.
//   clk, rst_n    : clock, async active-low reset
//   idx           : digit currently scanned (0..N_DIGITS-1)
//   sub           : sub-tick within the slot (0..15)
//   slot_end_c    : last cycle of a digit slot
//   frame_wrap_c  : last cycle of the last slot (idx wraps to 0 next)
module seg_prescaler #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned SUBTICK_DIV = 1024,
  parameter int unsigned IDX_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx,
  output logic [3:0]       sub,
  output logic             slot_end_c,
  output logic             frame_wrap_c
);

  localparam int unsigned DIV_W = (SUBTICK_DIV > 1) ? $clog2(SUBTICK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc_c;

  assign div_tc_c     = (div_cnt == DIV_W'(SUBTICK_DIV - 1));
  assign slot_end_c   = div_tc_c && (sub == 4'd15);
  assign frame_wrap_c = slot_end_c && (idx == IDX_W'(N_DIGITS - 1));

  // Counter chain div_cnt -> sub -> idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sub     <= '0;
      idx     <= '0;
    end else begin
      if (div_tc_c) begin
        div_cnt <= '0;
        sub     <= sub + 4'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (slot_end_c) begin
        idx <= frame_wrap_c ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with PWM brightness,
// per-digit blink, leading-zero suppression and a double-buffered update path.
//   clk, rst_n     : clock, async active-low reset
//   load           : capture vals/dp_mask/blink_mask/lz_en into pending buffer
//   vals           : 5-bit glyph code per digit
//   dp_mask        : decimal point per digit
//   blink_mask     : blink enable per digit
//   lz_en          : leading-zero suppression
//   brightness     : PWM duty, 0 = 1/16 .. 15 = full slot
//   pending        : buffered update waiting for the frame boundary
//   frame_start    : pulse aligned with digit 0 starting its slot
//   DIGIT          : active-low digit enables
//   DISPLAY, DP    : active-low segments {g,f,e,d,c,b,a} and decimal point
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SUBTICK_DIV  = 1024,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [CODE_W*N_DIGITS-1:0]   vals,
  input  logic [N_DIGITS-1:0]          dp_mask,
  input  logic [N_DIGITS-1:0]          blink_mask,
  input  logic                         lz_en,
  input  logic [3:0]                   brightness,
  output logic                         pending,
  output logic                         frame_start,
  output logic [N_DIGITS-1:0]          DIGIT,
  output logic [SEG_W-1:0]             DISPLAY,
  output logic                         DP
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned VAL_W = CODE_W * N_DIGITS;

  logic [IDX_W-1:0] idx;
  logic [3:0]       sub;
  logic             slot_end_c;
  logic             frame_wrap_c;
  logic             boundary_c;

  seg_prescaler #(
    .N_DIGITS    (N_DIGITS),
    .SUBTICK_DIV (SUBTICK_DIV),
    .IDX_W       (IDX_W)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx          (idx),
    .sub          (sub),
    .slot_end_c   (slot_end_c),
    .frame_wrap_c (frame_wrap_c)
  );

  // frame_wrap_c is only meaningful on a slot end
  assign boundary_c = slot_end_c && frame_wrap_c;

  logic [VAL_W-1:0]    vals_act,  vals_pnd;
  logic [N_DIGITS-1:0] dp_act,    dp_pnd;
  logic [N_DIGITS-1:0] blink_act, blink_pnd;
  logic                lz_act,    lz_pnd;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic                wrap_d;

  // Double buffer: pending copy applied at the frame boundary, a load on the
  // boundary itself goes straight to the active copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vals_act  <= '0;
      dp_act    <= '0;
      blink_act <= '0;
      lz_act    <= 1'b0;
      vals_pnd  <= '0;
      dp_pnd    <= '0;
      blink_pnd <= '0;
      lz_pnd    <= 1'b0;
      pending   <= 1'b0;
    end else if (boundary_c && load) begin
      vals_act  <= vals;
      dp_act    <= dp_mask;
      blink_act <= blink_mask;
      lz_act    <= lz_en;
      pending   <= 1'b0;
    end else if (boundary_c && pending) begin
      vals_act  <= vals_pnd;
      dp_act    <= dp_pnd;
      blink_act <= blink_pnd;
      lz_act    <= lz_pnd;
      pending   <= 1'b0;
    end else if (load) begin
      vals_pnd  <= vals;
      dp_pnd    <= dp_mask;
      blink_pnd <= blink_mask;
      lz_pnd    <= lz_en;
      pending   <= 1'b1;
    end
  end

  // Blink phase toggles every BLINK_FRAMES boundaries; frame_start trails the
  // boundary by two cycles to line up with the registered DIGIT[0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      wrap_d      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      wrap_d      <= boundary_c;
      frame_start <= wrap_d;
      if (boundary_c) begin
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  logic [N_DIGITS-1:0] lz_blank_c;
  logic                suppress_c;
  logic [CODE_W-1:0]   code_c;
  logic                dp_sel_c;
  logic                blink_sel_c;
  logic                blank_sel_c;
  logic                lit_c;

  // Leading-zero blanking from the top digit down; a lit dp ends suppression
  always_comb begin
    lz_blank_c = '0;
    suppress_c = lz_act;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      if (suppress_c && (vals_act[CODE_W*i +: CODE_W] == '0) && !dp_act[i]) begin
        lz_blank_c[i] = 1'b1;
      end else begin
        suppress_c = 1'b0;
      end
    end
  end

  // Select attributes of the scanned digit and decide whether it is lit
  always_comb begin
    code_c      = '0;
    dp_sel_c    = 1'b0;
    blink_sel_c = 1'b0;
    blank_sel_c = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        code_c      = vals_act[CODE_W*i +: CODE_W];
        dp_sel_c    = dp_act[i];
        blink_sel_c = blink_act[i];
        blank_sel_c = lz_blank_c[i];
      end
    end
    lit_c = (sub <= brightness) && !(blink_phase && blink_sel_c) && !blank_sel_c;
  end

  // Pins registered together so anodes and segments switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DIGIT   <= '1;
      DISPLAY <= SEG_OFF;
      DP      <= 1'b1;
    end else if (lit_c) begin
      DIGIT   <= ~(N_DIGITS'(1) << idx);
      DISPLAY <= glyph7(code_c);
      DP      <= ~dp_sel_c;
    end else begin
      DIGIT   <= '1;
      DISPLAY <= SEG_OFF;
      DP      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, SUBTICK_DIV=2,
// BLINK_FRAMES=2 (slot = 32 cycles, frame = 128 cycles).
// m counts rising edges since reset release; pins sampled after edge m
// reflect counter state m-1, and state 127 mod 128 is the frame boundary.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [19:0] vals;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  brightness;
  logic        pending;
  logic        frame_start;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;
  logic        DP;

  int n_checks = 0;
  int n_errors = 0;
  int m = 0;
  int low_cnt;

  seg_scan_ctrl #(
    .N_DIGITS     (4),
    .SUBTICK_DIV  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .vals        (vals),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .lz_en       (lz_en),
    .brightness  (brightness),
    .pending     (pending),
    .frame_start (frame_start),
    .DIGIT       (DIGIT),
    .DISPLAY     (DISPLAY),
    .DP          (DP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (m=%0d)", tag, obs, exp, m);
    end
  endtask

  // Advance to edge 'target' and sample 1 time unit after it
  task automatic goto(input int target);
    while (m < target) begin
      @(posedge clk);
      m++;
    end
    #1;
  endtask

  // Present a load for exactly one cycle (captured by the next edge)
  task automatic do_load(input logic [19:0] v, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz);
    vals       = v;
    dp_mask    = dp;
    blink_mask = bl;
    lz_en      = lz;
    load       = 1'b1;
    goto(m + 1);
    load       = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    vals       = '0;
    dp_mask    = '0;
    blink_mask = '0;
    lz_en      = 1'b0;
    brightness = 4'd15;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit",   32'(DIGIT),       32'hF);
    check("rst_display", 32'(DISPLAY),     32'h7F);
    check("rst_dp",      32'(DP),          32'h1);
    check("rst_pending", 32'(pending),     32'h0);
    check("rst_fstart",  32'(frame_start), 32'h0);
    #3 rst_n = 1'b1;
    m = 0;

    // 1. basic scan of {3,2,1,0}
    goto(2);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000, 1'b0);
    check("s1_pending_set", 32'(pending), 32'h1);
    goto(127);
    check("s1_pending_hold", 32'(pending), 32'h1);
    goto(128);
    check("s1_pending_clr", 32'(pending), 32'h0);
    goto(129);
    check("s1_d0_digit",  32'(DIGIT),       32'hE);
    check("s1_d0_disp",   32'(DISPLAY),     32'h40);
    check("s1_fstart",    32'(frame_start), 32'h1);
    goto(130);
    check("s1_fstart_off", 32'(frame_start), 32'h0);
    goto(161);
    check("s1_d1_digit", 32'(DIGIT),   32'hD);
    check("s1_d1_disp",  32'(DISPLAY), 32'h79);
    goto(193);
    check("s1_d2_digit", 32'(DIGIT),   32'hB);
    check("s1_d2_disp",  32'(DISPLAY), 32'h24);
    goto(225);
    check("s1_d3_digit", 32'(DIGIT),   32'h7);
    check("s1_d3_disp",  32'(DISPLAY), 32'h30);
    goto(256);
    check("s1_fstart_pre", 32'(frame_start), 32'h0);
    goto(257);
    check("s1_fstart_2", 32'(frame_start), 32'h1);
    check("s1_wrap_digit", 32'(DIGIT), 32'hE);

    // 2. brightness 3: digit 1 lit for sub 0..3 only
    brightness = 4'd3;
    low_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      goto(289 + k);
      if (DIGIT != 4'hF) low_cnt++;
      if (m == 296) check("s2_last_lit", 32'(DIGIT), 32'hD);
      if (m == 297) begin
        check("s2_dark_digit", 32'(DIGIT),   32'hF);
        check("s2_dark_disp",  32'(DISPLAY), 32'h7F);
        check("s2_dark_dp",    32'(DP),      32'h1);
      end
    end
    check("s2_low_count", 32'(low_cnt), 32'd8);

    // 3. leading-zero suppression, then dp stopping it
    goto(385);
    brightness = 4'd15;
    do_load({5'd0, 5'd0, 5'd0, 5'd5}, 4'b0000, 4'b0000, 1'b1);
    goto(513);
    check("s3_d0_digit", 32'(DIGIT),   32'hE);
    check("s3_d0_disp",  32'(DISPLAY), 32'h12);
    goto(545);
    check("s3_d1_blank", 32'(DIGIT),   32'hF);
    check("s3_d1_disp",  32'(DISPLAY), 32'h7F);
    goto(577);
    check("s3_d2_blank", 32'(DIGIT), 32'hF);
    goto(609);
    check("s3_d3_blank", 32'(DIGIT), 32'hF);
    goto(641);
    do_load({5'd0, 5'd0, 5'd0, 5'd5}, 4'b0100, 4'b0000, 1'b1);
    goto(769);
    check("s3dp_d0_disp", 32'(DISPLAY), 32'h12);
    check("s3dp_d0_dp",   32'(DP),      32'h1);
    goto(801);
    check("s3dp_d1_digit", 32'(DIGIT),   32'hD);
    check("s3dp_d1_disp",  32'(DISPLAY), 32'h40);
    goto(833);
    check("s3dp_d2_digit", 32'(DIGIT),   32'hB);
    check("s3dp_d2_disp",  32'(DISPLAY), 32'h40);
    check("s3dp_d2_dp",    32'(DP),      32'h0);
    goto(865);
    check("s3dp_d3_blank", 32'(DIGIT), 32'hF);

    // 4. blink digit 1: dark in frames with (frame/2) odd
    goto(897);
    do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0010, 1'b0);
    goto(1057);
    check("s4_f8_d1_on", 32'(DIGIT), 32'hD);
    goto(1281);
    check("s4_f10_d0_on", 32'(DIGIT), 32'hE);
    goto(1313);
    check("s4_f10_d1_off",  32'(DIGIT),   32'hF);
    check("s4_f10_d1_disp", 32'(DISPLAY), 32'h7F);
    goto(1345);
    check("s4_f10_d2_on", 32'(DIGIT),   32'hB);
    check("s4_f10_d2_disp", 32'(DISPLAY), 32'h24);
    goto(1441);
    check("s4_f11_d1_off", 32'(DIGIT), 32'hF);
    goto(1569);
    check("s4_f12_d1_on", 32'(DIGIT), 32'hD);

    // 5. double buffer: last load wins, boundary load bypasses
    goto(1700);
    do_load({5'd3, 5'd3, 5'd3, 5'd3}, 4'b0000, 4'b0000, 1'b0);
    check("s5_pend_a", 32'(pending), 32'h1);
    goto(1750);
    do_load({5'd9, 5'd8, 5'd7, 5'd6}, 4'b0000, 4'b0000, 1'b0);
    goto(1791);
    check("s5_pend_hold", 32'(pending), 32'h1);
    goto(1792);
    check("s5_pend_clr", 32'(pending), 32'h0);
    goto(1793);
    check("s5_b_d0", 32'(DISPLAY), 32'h02);
    goto(1825);
    check("s5_b_d1", 32'(DISPLAY), 32'h78);
    goto(1857);
    check("s5_b_d2", 32'(DISPLAY), 32'h00);
    goto(1889);
    check("s5_b_d3", 32'(DISPLAY), 32'h10);
    goto(1919);
    do_load({5'd1, 5'd1, 5'd1, 5'd4}, 4'b0000, 4'b0000, 1'b0);
    check("s5_bypass_pend", 32'(pending), 32'h0);
    goto(1921);
    check("s5_bypass_pend2", 32'(pending), 32'h0);
    check("s5_bypass_digit", 32'(DIGIT),   32'hE);
    check("s5_bypass_disp",  32'(DISPLAY), 32'h19);

    // 6. reset during digit 2's slot
    goto(1990);
    check("s6_pre_digit", 32'(DIGIT), 32'hB);
    rst_n = 1'b0;
    #1;
    check("s6_rst_digit",   32'(DIGIT),   32'hF);
    check("s6_rst_display", 32'(DISPLAY), 32'h7F);
    check("s6_rst_dp",      32'(DP),      32'h1);
    check("s6_rst_pending", 32'(pending), 32'h0);
    #2 rst_n = 1'b1;
    m = 0;
    goto(1);
    check("s6_d0_digit",  32'(DIGIT),       32'hE);
    check("s6_d0_disp",   32'(DISPLAY),     32'h40);
    check("s6_d0_fstart", 32'(frame_start), 32'h0);
    goto(33);
    check("s6_d1_digit", 32'(DIGIT),   32'hD);
    check("s6_d1_disp",  32'(DISPLAY), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
